// File: rtl/hs_ctrl_pkg.sv
// hs_ctrl_pkg: sequencer state type, default frame geometry and address sizing helper
// shared by the Horn-Schunck pass sequencer and its raster counters.
package hs_ctrl_pkg;

  // Sequencer phases: waiting for a start, reading passes, waiting for the last output frame
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } hs_state_e;

  localparam int IMAGE_WIDTH_DEF  = 512;
  localparam int IMAGE_HEIGHT_DEF = 256;
  localparam int IMAGE_SIZE       = IMAGE_WIDTH_DEF * IMAGE_HEIGHT_DEF;

  // Bits needed to hold every pixel offset 0 .. pixels-1 (never less than one bit)
  function automatic int addr_width(input int pixels);
    return (pixels <= 2) ? 1 : $clog2(pixels);
  endfunction

endpackage

// File: rtl/hs_raster_counter.sv
// hs_raster_counter: pixel offset counter in raster order. Synchronous clear to zero,
// advances when enabled, and flags the last pixel of the frame so the owner can react
// on the same cycle the counter folds back to zero.
module hs_raster_counter
  import hs_ctrl_pkg::*;
#(
  parameter int SIZE = IMAGE_SIZE,
  parameter int W    = addr_width(SIZE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(SIZE - 1);

  assign wrap = (count == LAST);

  // Step through pixel offsets, folding back to zero after the last pixel of the frame
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/hs_pass_sequencer.sv
// hs_pass_sequencer: drives the frame-buffer read raster for repeated Horn-Schunck passes,
// marks pixel 0 of each pass towards the datapath (delayed to match the buffer read latency),
// follows the frames coming back out of the datapath and reports completion or timeout.
// The output-frame view (io_out_valid / io_out_addr) is registered, so it describes the
// datapath pixel stream one cycle after the datapath presents it.
module hs_pass_sequencer
  import hs_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH   = 512,
  parameter int IMAGE_HEIGHT  = 256,
  parameter int ADDR_W        = addr_width(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int ITER_W        = 8,
  parameter int RD_LATENCY    = 1,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ITER_W-1:0] io_num_iters,
  output logic              io_rd_en,
  output logic [ADDR_W-1:0] io_rd_addr,
  output logic              io_frame_sync_in,
  input  logic              io_frame_sync_out,
  output logic              io_out_valid,
  output logic [ADDR_W-1:0] io_out_addr,
  output logic [ITER_W-1:0] io_pass_idx,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_error
);

  localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int DRAIN_W      = $clog2(DRAIN_TIMEOUT + 1);

  hs_state_e           state;
  hs_state_e           state_next;

  logic [ITER_W-1:0]   num_iters_q;
  logic [ITER_W-1:0]   pass_idx_q;
  logic [ITER_W-1:0]   frames_seen;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [RD_LATENCY-1:0] sync_dly;

  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                rd_wrap;
  logic                out_wrap;
  logic                out_valid_q;
  logic                done_q;
  logic                error_q;

  logic                start_accept;
  logic                last_pass;
  logic                tracking;
  logic                sync_hit;
  logic                restart_err;
  logic                frame_end;
  logic                frames_done;
  logic                drain_timeout;
  logic                drain_exit;
  logic                done_set;
  logic                pix0_read;

  // Decode the control events that the registers below react to
  assign start_accept  = (state == IDLE) && io_start;
  assign last_pass     = (pass_idx_q == num_iters_q - ITER_W'(1));
  assign tracking      = (state != IDLE);
  assign sync_hit      = tracking && io_frame_sync_out;
  assign restart_err   = sync_hit && out_valid_q && !out_wrap;
  assign frame_end     = tracking && out_valid_q && out_wrap;
  assign frames_done   = (frames_seen == num_iters_q);
  assign drain_timeout = (state == DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1));
  assign drain_exit    = (state == DRAIN) && (frames_done || drain_timeout);
  assign done_set      = (start_accept && (io_num_iters == '0)) || drain_exit;
  assign pix0_read     = io_rd_en && (rd_addr_q == '0);

  // Read-side raster: restarts on an accepted start, advances every STREAM cycle
  hs_raster_counter #(
    .SIZE (FRAME_PIXELS),
    .W    (ADDR_W)
  ) u_rd_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_accept),
    .enable (state == STREAM),
    .count  (rd_addr_q),
    .wrap   (rd_wrap)
  );

  // Output-side raster: restarts on every datapath frame sync, parked at zero when not tracking
  hs_raster_counter #(
    .SIZE (FRAME_PIXELS),
    .W    (ADDR_W)
  ) u_out_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (sync_hit || (state == IDLE) || drain_exit),
    .enable (out_valid_q),
    .count  (out_addr_q),
    .wrap   (out_wrap)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: stream passes back to back, then drain until the last frame returns
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_accept && (io_num_iters != '0)) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (rd_wrap && last_pass) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_exit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs: read strobe only while streaming, busy in every non-IDLE state
  always_comb begin
    io_rd_en = 1'b0;
    io_busy  = 1'b0;
    case (state)
      STREAM: begin
        io_rd_en = 1'b1;
        io_busy  = 1'b1;
      end
      DRAIN: begin
        io_busy = 1'b1;
      end
      default: begin
        io_rd_en = 1'b0;
        io_busy  = 1'b0;
      end
    endcase
  end

  // Latch the requested pass count and step the pass index at each raster wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      num_iters_q <= '0;
      pass_idx_q  <= '0;
    end else if (start_accept) begin
      num_iters_q <= io_num_iters;
      pass_idx_q  <= '0;
    end else if ((state == STREAM) && rd_wrap && !last_pass) begin
      pass_idx_q <= pass_idx_q + ITER_W'(1);
    end
  end

  // Delay the pixel-0 marker so it lines up with the frame-buffer read data
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_dly <= '0;
    end else begin
      sync_dly[0] <= pix0_read;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sync_dly[i] <= sync_dly[i-1];
      end
    end
  end

  // Follow the datapath output stream and count every frame that completes
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      frames_seen <= '0;
    end else begin
      if ((state == IDLE) || drain_exit) begin
        out_valid_q <= 1'b0;
      end else if (sync_hit) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_wrap) begin
        out_valid_q <= 1'b0;
      end
      if (start_accept) begin
        frames_seen <= '0;
      end else if (frame_end && (frames_seen != '1)) begin
        frames_seen <= frames_seen + ITER_W'(1);
      end
    end
  end

  // Count cycles spent waiting for the final output frame
  always_ff @(posedge clk) begin
    if (reset || (state != DRAIN)) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  // Completion pulse and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= done_set;
      if (start_accept) begin
        error_q <= 1'b0;
      end else if (restart_err || (drain_timeout && !frames_done)) begin
        error_q <= 1'b1;
      end
    end
  end

  assign io_rd_addr       = rd_addr_q;
  assign io_frame_sync_in = sync_dly[RD_LATENCY-1];
  assign io_out_valid     = out_valid_q;
  assign io_out_addr      = out_addr_q;
  assign io_pass_idx      = pass_idx_q;
  assign io_done          = done_q;
  assign io_error         = error_q;

endmodule
